fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one sync_fifo write port among NUM_REQ producers.
- Each producer has a valid/ready handshake. The block forwards the granted producer's data onto the FIFO's wr_en/din and honours the FIFO's full flag.
- A grant is held for a burst of up to MAX_BURST beats, then the grant rotates so no producer starves.

Parameters:
- NUM_REQ, 4, number of producers (>=2).
- DATA_WIDTH, 8, data width; must match the FIFO DATA_WIDTH.
- MAX_BURST, 4, maximum beats per grant (>=1).
- ID_WIDTH (localparam), max(1, $clog2(NUM_REQ)), width of grant_id.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  producer i has data.
- req_data  input  NUM_REQ*DATA_WIDTH  producer i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  producer i beat accepted this cycle.
- fifo_full  input  1  FIFO full flag.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_din  output  DATA_WIDTH  FIFO write data.
- grant_vld  output  1  a producer currently holds the grant.
- grant_id  output  ID_WIDTH  index of the granted producer.

Behaviour:
- Clock and reset: one clock, clk; asynchronous active-low reset, rst_n.
- Reset values:
  - state=IDLE, grant_vld=0, grant_id=0, beat_cnt=0, last_id=NUM_REQ-1 (so req 0 has first priority).
  - req_ready=0, fifo_wr_en=0.
  - fifo_din is don't-care; drive it with the grant_id mux output.
- Registered state: state {IDLE, BURST}, grant_id, last_id, beat_cnt (width $clog2(MAX_BURST)+1).
- Combinational outputs, valid only in BURST:
  - req_ready[i] = (state==BURST) && (i==grant_id) && !fifo_full.
  - fifo_wr_en = req_valid[grant_id] && req_ready[grant_id].
  - fifo_din = req_data slice at grant_id.
  - Zero data latency: the beat is written to the FIFO on the same edge it is accepted.
- Transfer: a beat transfers when req_valid[i] && req_ready[i]. Producers must hold valid and data stable until ready.
- IDLE:
  - If any req_valid is set, select the first set bit scanning last_id+1, last_id+2, ... modulo NUM_REQ.
  - Next edge: grant_id<=selection, state<=BURST, beat_cnt<=0.
  - Arbitration costs exactly 1 cycle; no transfer happens in IDLE.
  - fifo_full does not block granting.
- BURST:
  - Transfer with beat_cnt==MAX_BURST-1: state<=IDLE, last_id<=grant_id.
  - Transfer otherwise: beat_cnt<=beat_cnt+1.
  - req_valid[grant_id]==0: state<=IDLE, last_id<=grant_id, no transfer. The burst ends early.
  - fifo_full with valid high: stall. Hold state, beat_cnt and grant; stalled cycles do not count as beats.
- Grant visibility: grant_vld = (state==BURST).
- Requests from non-granted producers are ignored until the grant returns to IDLE.
- Fairness: a producer that is continuously valid is granted within NUM_REQ arbitrations.
- MAX_BURST==1: every transfer returns the arbiter to IDLE.
- Reset mid-burst: everything returns to reset values immediately (asynchronous). No write is issued while rst_n is low.
- No combinational path from req_valid to req_ready.
- Paths from fifo_full to req_ready and from fifo_full to fifo_wr_en are permitted.

Test Plan:
- Single producer: req 0 valid with data 0x11,0x22,0x33,0x44,0x55, MAX_BURST=4, FIFO empty.
  - 1 idle cycle, then 4 consecutive writes 0x11..0x44.
  - 1 re-arbitration cycle, then 0x55.
  - FIFO read-back order matches.
- Round robin: req 0..3 all continuously valid.
  - Grant sequence 0,1,2,3,0 with 4 beats each.
  - grant_id changes only after the 4th beat; 1-cycle gap between bursts.
- Full stall: FIFO pre-filled to 15 of 16; req 2 sends 3 beats.
  - One write, then fifo_full=1 and req_ready=0 with grant held and beat_cnt unchanged.
  - After an external read, the remaining beats complete in order with no loss or duplication.
- Early termination: req 1 drops valid after 2 beats while req 3 is valid.
  - Arbiter returns to IDLE and grants req 3 next.
  - last_id=1 is reflected in the next priority scan.
- Reset mid-burst: rst_n pulsed low during beat 2 of a req 0 burst.
  - grant_vld=0 and fifo_wr_en=0 immediately.
  - After release, req 0 has priority again.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin arbiter sharing one FIFO write port among NUM_REQ
//            valid/ready producers. Each grant lasts a burst of up to
//            MAX_BURST beats, then the grant rotates to the next producer.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic                          grant_vld,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id
);

    localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_WIDTH = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(MAX_BURST - 1);
    localparam logic [ID_WIDTH-1:0]  LAST_REQ  = ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                state_q,    state_d;
    logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic [ID_WIDTH-1:0]   last_id_q,  last_id_d;
    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;

    logic                  any_valid;
    logic                  found_hi;
    logic                  found_lo;
    logic [ID_WIDTH-1:0]   sel_hi;
    logic [ID_WIDTH-1:0]   sel_lo;
    logic [ID_WIDTH-1:0]   sel_id;
    logic                  gnt_valid;
    logic                  in_burst;

    // Round-robin pick: first valid index above last_id, else wrap to the
    // first valid index at or below last_id.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_hi && req_valid[i] && (ID_WIDTH'(i) > last_id_q)) begin
                found_hi = 1'b1;
                sel_hi   = ID_WIDTH'(i);
            end
            if (!found_lo && req_valid[i] && (ID_WIDTH'(i) <= last_id_q)) begin
                found_lo = 1'b1;
                sel_lo   = ID_WIDTH'(i);
            end
        end
        any_valid = found_hi || found_lo;
        sel_id    = found_hi ? sel_hi : sel_lo;
    end

    // Route the granted producer's valid and data through a constant-index mux.
    always_comb begin
        gnt_valid = 1'b0;
        fifo_din  = req_data[DATA_WIDTH-1:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == ID_WIDTH'(i)) begin
                gnt_valid = req_valid[i];
                fifo_din  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and handshake outputs; ready never depends on req_valid.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        beat_cnt_d = beat_cnt_q;
        in_burst   = (state_q == BURST);
        grant_vld  = in_burst;
        grant_id   = grant_id_q;
        req_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = in_burst && (grant_id_q == ID_WIDTH'(i)) && !fifo_full;
        end
        fifo_wr_en = in_burst && gnt_valid && !fifo_full;

        case (state_q)
            IDLE: begin
                // Arbitration takes one cycle; fifo_full does not block it.
                if (any_valid) begin
                    state_d    = BURST;
                    grant_id_d = sel_id;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (!gnt_valid) begin
                    // Producer went quiet: end the burst early.
                    state_d   = IDLE;
                    last_id_d = grant_id_q;
                end else if (!fifo_full) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d   = IDLE;
                        last_id_d = grant_id_q;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
                // Full with valid high: stall, everything held.
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset gives producer 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            last_id_q  <= LAST_REQ;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Self-checking bench for fifo_wr_arbiter with a behavioural
//            arbiter model, a 16-entry FIFO stand-in and queued producers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;
    localparam int FIFO_DEPTH = 16;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_din;
    logic                          grant_vld;
    logic [1:0]                    grant_id;

    int n_tests = 0;
    int n_fail  = 0;

    // Producer pending-beat queues, beats already written, FIFO contents.
    logic [7:0] pq     [NUM_REQ][$];
    logic [7:0] sent_q [NUM_REQ][$];
    logic [7:0] fq [$];
    int         fid [$];
    bit [NUM_REQ-1:0] acc = '0;
    logic [5:0] seq [NUM_REQ];
    int  rd_pct    = 100;
    bit  rand_mode = 1'b0;

    // Behavioural arbiter state
    bit m_busy;
    int m_gid;
    int m_last;
    int m_beats;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .grant_vld  (grant_vld),
        .grant_id   (grant_id)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Compare outputs mid-cycle, then advance model, FIFO and scoreboard on the edge.
    initial begin : compare
        logic                          s_wr;
        logic                          s_full;
        logic                          exp_wr;
        logic [7:0]                    s_din;
        logic [7:0]                    d;
        logic [NUM_REQ-1:0]            s_valid;
        logic [NUM_REQ*DATA_WIDTH-1:0] s_data;
        int                            id;
        int                            p;
        m_busy = 1'b0; m_gid = 0; m_last = NUM_REQ - 1; m_beats = 0;
        forever begin
            @(negedge clk); #1;
            s_wr    = fifo_wr_en;
            s_din   = fifo_din;
            s_valid = req_valid;
            s_data  = req_data;
            s_full  = fifo_full;
            exp_wr  = m_busy && s_valid[m_gid] && !s_full;
            if (rst_n) begin
                chk("grant_vld", 32'(grant_vld), 32'(m_busy));
                chk("grant_id", 32'(grant_id), 32'(m_gid));
                chk("req_ready", 32'(req_ready), (m_busy && !s_full) ? (32'd1 << m_gid) : 32'd0);
                chk("fifo_wr_en", 32'(s_wr), 32'(exp_wr));
                if (exp_wr) chk("fifo_din", 32'(s_din), 32'(s_data[m_gid*DATA_WIDTH +: DATA_WIDTH]));
            end
            @(posedge clk);
            if (!rst_n) begin
                m_busy = 1'b0; m_gid = 0; m_last = NUM_REQ - 1; m_beats = 0;
            end else begin
                if (fq.size() > 0 && $urandom_range(99) < rd_pct) begin
                    d  = fq.pop_front();
                    id = fid.pop_front();
                    if (id >= 0) begin
                        if (sent_q[id].size() == 0) chk("readback_extra", 32'(d), 32'hFFFF_FFFF);
                        else chk("readback_order", 32'(d), 32'(sent_q[id].pop_front()));
                    end
                end
                if (s_wr) begin
                    fq.push_back(s_din);
                    fid.push_back(m_gid);
                end
                if (exp_wr) begin
                    sent_q[m_gid].push_back(s_data[m_gid*DATA_WIDTH +: DATA_WIDTH]);
                    acc[m_gid] = 1'b1;
                end
                if (!m_busy) begin
                    p = rr_pick(s_valid, m_last);
                    if (p >= 0) begin
                        m_busy = 1'b1; m_gid = p; m_beats = 0;
                    end
                end else if (!s_valid[m_gid]) begin
                    m_busy = 1'b0; m_last = m_gid;
                end else if (!s_full) begin
                    m_beats++;
                    if (m_beats == MAX_BURST) begin
                        m_busy = 1'b0; m_last = m_gid;
                    end
                end
            end
        end
    end

    // One producer cycle: retire accepted beats, optionally create new ones, drive.
    task automatic step();
        @(negedge clk);
        for (int p = 0; p < NUM_REQ; p++) begin
            if (acc[p]) begin
                if (pq[p].size() > 0) void'(pq[p].pop_front());
                acc[p] = 1'b0;
            end
            if (rand_mode && pq[p].size() == 0 && $urandom_range(99) < 35) begin
                pq[p].push_back({2'(p), seq[p]});
                seq[p] = seq[p] + 6'd1;
            end
            req_valid[p] = (pq[p].size() > 0);
            req_data[p*DATA_WIDTH +: DATA_WIDTH] = (pq[p].size() > 0) ? pq[p][0] : 8'h00;
        end
        fifo_full = (fq.size() >= FIFO_DEPTH);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_grant_vld", 32'(grant_vld), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        rand_mode = 1'b0;
        rd_pct    = 100;
        repeat (n) step();
    endtask

    initial begin : stimulus
        logic [7:0] t1_din [8];
        logic       t1_wr  [8];
        rst_n = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
        for (int p = 0; p < NUM_REQ; p++) seq[p] = 6'd0;
        t1_wr  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        t1_din = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h55, 8'h00};
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_grant_vld", 32'(grant_vld), 32'd0);
        chk("reset_grant_id", 32'(grant_id), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_wr_en", 32'(fifo_wr_en), 32'd0);
        rst_n = 1'b1;

        // Single producer, five beats, burst of four then re-arbitration.
        pq[0].push_back(8'h11); pq[0].push_back(8'h22); pq[0].push_back(8'h33);
        pq[0].push_back(8'h44); pq[0].push_back(8'h55);
        for (int k = 0; k < 8; k++) begin
            step(); #2;
            chk("single_wr_en", 32'(fifo_wr_en), 32'(t1_wr[k]));
            if (t1_wr[k]) chk("single_din", 32'(fifo_din), 32'(t1_din[k]));
        end
        drain(10);

        // All four producers continuously valid.
        do_reset();
        for (int p = 0; p < NUM_REQ; p++)
            for (int j = 0; j < 8; j++) pq[p].push_back(8'((p << 4) | j));
        for (int k = 0; k < 25; k++) begin
            step(); #2;
            if (k % 5 == 1) chk("rr_grant_id", 32'(grant_id), 32'((k / 5) % NUM_REQ));
            if (k % 5 == 0) chk("rr_gap", 32'(grant_vld), 32'd0);
        end
        drain(60);

        // FIFO one short of full, producer 2 sends three beats.
        do_reset();
        rd_pct = 0;
        for (int j = 0; j < FIFO_DEPTH - 1; j++) begin
            fq.push_back(8'hEE); fid.push_back(-1);
        end
        pq[2].push_back(8'hA0); pq[2].push_back(8'hA1); pq[2].push_back(8'hA2);
        step(); step(); #2;
        chk("stall_first_wr", 32'(fifo_wr_en), 32'd1);
        chk("stall_first_din", 32'(fifo_din), 32'hA0);
        for (int k = 2; k < 4; k++) begin
            step(); #2;
            chk("stall_full", 32'(fifo_full), 32'd1);
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_wr_en", 32'(fifo_wr_en), 32'd0);
            chk("stall_grant", 32'({grant_vld, grant_id}), 32'({1'b1, 2'd2}));
        end
        rd_pct = 100;
        step(); #2;
        chk("resume_din1", 32'({fifo_wr_en, fifo_din}), 32'h1A1);
        step(); #2;
        chk("resume_din2", 32'({fifo_wr_en, fifo_din}), 32'h1A2);
        drain(30);

        // Producer 1 stops after two beats; 0 and 3 compete afterwards.
        do_reset();
        pq[1].push_back(8'hB0); pq[1].push_back(8'hB1);
        for (int j = 0; j < 6; j++) pq[3].push_back(8'hC0 + 8'(j));
        step(); step(); #2;
        chk("early_din0", 32'({fifo_wr_en, fifo_din}), 32'h1B0);
        step(); #2;
        chk("early_din1", 32'({fifo_wr_en, fifo_din}), 32'h1B1);
        for (int j = 0; j < 4; j++) pq[0].push_back(8'hD0 + 8'(j));
        step(); #2;
        chk("early_end_wr", 32'(fifo_wr_en), 32'd0);
        step(); #2;
        chk("early_idle", 32'(grant_vld), 32'd0);
        step(); #2;
        chk("early_next_grant", 32'({grant_vld, grant_id}), 32'({1'b1, 2'd3}));
        drain(60);

        // Reset pulse during the second beat of a producer 0 burst.
        do_reset();
        for (int j = 0; j < 6; j++) pq[0].push_back(8'h60 + 8'(j));
        for (int j = 0; j < 2; j++) pq[3].push_back(8'h70 + 8'(j));
        step(); step(); step(); #2;
        chk("mid_beat2_wr", 32'(fifo_wr_en), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(grant_vld), 32'd0);
        chk("mid_rst_wr", 32'(fifo_wr_en), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(); #2;
        chk("mid_post_idle", 32'(grant_vld), 32'd0);
        step(); #2;
        chk("mid_post_grant", 32'({grant_vld, grant_id}), 32'({1'b1, 2'd0}));
        drain(60);

        // Random producers and random FIFO drain rate.
        rand_mode = 1'b1;
        for (int blk = 0; blk < 15; blk++) begin
            case ($urandom_range(3))
                0: rd_pct = 0;
                1: rd_pct = 30;
                2: rd_pct = 70;
                default: rd_pct = 100;
            endcase
            repeat (200) step();
        end
        drain(120);
        chk("fifo_drained", 32'(fq.size()), 32'd0);
        for (int p = 0; p < NUM_REQ; p++) begin
            chk("all_beats_read", 32'(sent_q[p].size()), 32'd0);
            chk("all_beats_sent", 32'(pq[p].size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
